// File: rtl/keymem_client_if.sv
// Key-memory client bus: lookup port from the NTS packet engine, request
// port towards keymem_top, and the statistics/cache control signals.
interface keymem_client_if;
    logic         lookup_req;
    logic [31:0]  lookup_id;
    logic         lookup_ready;
    logic         lookup_ack;
    logic         lookup_ok;
    logic         lookup_hit;
    logic [255:0] lookup_key;
    logic         cache_flush;

    logic         key_req;
    logic [31:0]  key_id;
    logic         key_ack;
    logic [255:0] key;

    logic         cnt_clear;
    logic [31:0]  cnt_lookups;
    logic [31:0]  cnt_hits;
    logic [31:0]  cnt_timeouts;

    // Environment side: packet engine, keymem_top and software registers.
    modport master (
        output lookup_req, lookup_id, cache_flush, key_ack, key, cnt_clear,
        input  lookup_ready, lookup_ack, lookup_ok, lookup_hit, lookup_key,
        input  key_req, key_id, cnt_lookups, cnt_hits, cnt_timeouts
    );

    // Client side: the keymem_client block itself.
    modport slave (
        input  lookup_req, lookup_id, cache_flush, key_ack, key, cnt_clear,
        output lookup_ready, lookup_ack, lookup_ok, lookup_hit, lookup_key,
        output key_req, key_id, cnt_lookups, cnt_hits, cnt_timeouts
    );
endinterface

// File: rtl/keymem_client.sv
// Key-memory client: single-entry key cache in front of a four-phase
// key_req/key_ack handshake to keymem_top, with a per-request timeout and
// saturating lookup/hit/timeout statistics.
module keymem_client #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
    parameter logic        CACHE_EN       = 1'b1
) (
    input logic            key_clk,
    input logic            key_aresetn,
    keymem_client_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    tmo_q, tmo_d;
    logic [31:0]    key_id_q;

    logic           cache_valid_q;
    logic [31:0]    cache_id_q;
    logic [255:0]   cache_key_q;

    logic           ack_q, ok_q, hit_q;
    logic [255:0]   key_q;

    logic [31:0]    cnt_lookups_q, cnt_hits_q, cnt_timeouts_q;

    logic           accept, hit, miss, fill, timeout;

    // Next-state decode: cache hit check in IDLE, ack/timeout race in REQ,
    // wait for keymem to drop its ack in RELEASE.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        accept  = 1'b0;
        hit     = 1'b0;
        miss    = 1'b0;
        fill    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.lookup_req) begin
                    accept = 1'b1;
                    if (CACHE_EN && cache_valid_q && (bus.lookup_id == cache_id_q)
                        && !bus.cache_flush) begin
                        hit = 1'b1;
                    end else begin
                        miss    = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.key_ack) begin
                    fill    = 1'b1;
                    tmo_d   = '0;
                    state_d = RELEASE;
                end else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                    timeout = 1'b1;
                    tmo_d   = '0;
                    state_d = RELEASE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RELEASE: begin
                if (!bus.key_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timeout counter and the latched request id.
    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            key_id_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (miss) begin
                key_id_q <= bus.lookup_id;
            end
        end
    end

    // Response register; lookup_key holds its value between responses.
    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            ack_q <= 1'b0;
            ok_q  <= 1'b0;
            hit_q <= 1'b0;
            key_q <= '0;
        end else begin
            ack_q <= hit | fill | timeout;
            ok_q  <= hit | fill;
            hit_q <= hit;
            if (hit) begin
                key_q <= cache_key_q;
            end else if (fill) begin
                key_q <= bus.key;
            end else if (timeout) begin
                key_q <= '0;
            end
        end
    end

    // Single-entry cache; a flush always beats a fill in the same cycle.
    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            cache_valid_q <= 1'b0;
            cache_id_q    <= '0;
            cache_key_q   <= '0;
        end else if (bus.cache_flush) begin
            cache_valid_q <= 1'b0;
        end else if (fill) begin
            cache_valid_q <= 1'b1;
            cache_id_q    <= key_id_q;
            cache_key_q   <= bus.key;
        end
    end

    // Saturating statistics; clear takes priority over any increment.
    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            cnt_lookups_q  <= '0;
            cnt_hits_q     <= '0;
            cnt_timeouts_q <= '0;
        end else if (bus.cnt_clear) begin
            cnt_lookups_q  <= '0;
            cnt_hits_q     <= '0;
            cnt_timeouts_q <= '0;
        end else begin
            if (accept && (cnt_lookups_q != '1)) begin
                cnt_lookups_q <= cnt_lookups_q + 32'd1;
            end
            if (hit && (cnt_hits_q != '1)) begin
                cnt_hits_q <= cnt_hits_q + 32'd1;
            end
            if (timeout && (cnt_timeouts_q != '1)) begin
                cnt_timeouts_q <= cnt_timeouts_q + 32'd1;
            end
        end
    end

    assign bus.lookup_ready = (state_q == IDLE);
    assign bus.key_req      = (state_q == REQ);
    assign bus.key_id       = key_id_q;
    assign bus.lookup_ack   = ack_q;
    assign bus.lookup_ok    = ok_q;
    assign bus.lookup_hit   = hit_q;
    assign bus.lookup_key   = key_q;
    assign bus.cnt_lookups  = cnt_lookups_q;
    assign bus.cnt_hits     = cnt_hits_q;
    assign bus.cnt_timeouts = cnt_timeouts_q;

endmodule
